// File: rtl/pst_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pst_pkg                                                                    |
// | Shared phase width and transmitter state encoding for phase-coded blocks.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pst_pkg;

  localparam int PHASE_W = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_ARMED = 2'd1,
    TX_DONE  = 2'd2
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/phase_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | phase_fifo                                                                 |
// | Synchronous FIFO with occupancy count and same-clock push/pop.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module phase_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == CNT_W'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;
  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/phase_spike_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | phase_spike_tx                                                             |
// | Queues target phases and fires one spike per gamma cycle at that phase.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module phase_spike_tx
  import pst_pkg::*;
#(
  parameter int PHASE_W    = pst_pkg::PHASE_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cycle_start,
  input  logic [PHASE_W-1:0] global_phase,
  input  logic [PHASE_W-1:0] in_phase,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               spike_out,
  output logic [PHASE_W-1:0] spike_phase,
  output logic               armed,
  output logic               missed,
  output logic [CNT_W-1:0]   fifo_count
);

  tx_state_t          r_state;
  logic [PHASE_W-1:0] r_target;
  logic [PHASE_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;

  assign in_ready = !w_full;
  assign armed    = (r_state == TX_ARMED);

  phase_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PHASE_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid),
    .wr_data (in_phase),
    .pop     (cycle_start),
    .rd_data (w_head),
    .count   (fifo_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  // A cycle_start always wins: an unreached target is reported and replaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= TX_IDLE;
      r_target    <= '0;
      spike_out   <= 1'b0;
      spike_phase <= '0;
      missed      <= 1'b0;
    end else begin
      spike_out <= 1'b0;
      missed    <= 1'b0;
      if (cycle_start) begin
        missed <= (r_state == TX_ARMED);
        if (!w_empty) begin
          r_target <= w_head;
          if (w_head == '0) begin
            spike_out   <= 1'b1;
            spike_phase <= '0;
            r_state     <= TX_DONE;
          end else begin
            r_state <= TX_ARMED;
          end
        end else begin
          r_state <= TX_IDLE;
        end
      end else if ((r_state == TX_ARMED) && (global_phase == r_target)) begin
        r_state     <= TX_DONE;
        spike_out   <= 1'b1;
        spike_phase <= r_target;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phase_spike_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_phase_spike_tx                                                          |
// | Scoreboard bench with an in-bench gamma oscillator and reference model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_phase_spike_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cycle_start;
  logic [7:0] global_phase;
  logic [7:0] in_phase = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       spike_out;
  logic [7:0] spike_phase;
  logic       armed;
  logic       missed;
  logic [2:0] fifo_count;

  phase_spike_tx #(
    .PHASE_W    (8),
    .FIFO_DEPTH (4),
    .CNT_W      (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cycle_start  (cycle_start),
    .global_phase (global_phase),
    .in_phase     (in_phase),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .spike_out    (spike_out),
    .spike_phase  (spike_phase),
    .armed        (armed),
    .missed       (missed),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  // Gamma oscillator: a new length takes effect only at a cycle boundary.
  int phase   = 0;
  int cur_len = 256;
  int req_len = 256;
  assign global_phase = 8'(phase);
  assign cycle_start  = (phase == 0);

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (phase >= cur_len - 1) begin
        phase   = 0;
        cur_len = req_len;
      end else begin
        phase = phase + 1;
      end
    end
  end

  typedef struct {
    bit         is_miss;
    logic [7:0] ph;
    int         len;
  } ev_t;

  ev_t        sb[$];
  logic [7:0] mq[$];
  bit         m_armed  = 1'b0;
  logic [7:0] m_target = 8'd0;
  logic [7:0] last_sp  = 8'd0;
  int         n_tests  = 0;
  int         n_fail   = 0;
  bit         chk_on   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: one target per gamma cycle, taken from a 4-deep queue.
  logic [7:0] mt;
  bit         m_full;
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        sb.delete();
        m_armed = 1'b0;
        last_sp = 8'd0;
      end else begin
        m_full = (mq.size() >= 4);
        if (cycle_start) begin
          if (mq.size() > 0) begin
            mt       = mq.pop_front();
            m_target = mt;
            m_armed  = (mt != 8'd0);
            sb.push_back('{is_miss: (int'(mt) >= cur_len), ph: mt, len: cur_len});
          end else begin
            m_armed = 1'b0;
          end
        end else if (m_armed && global_phase == m_target) begin
          m_armed = 1'b0;
        end
        if (in_valid && !m_full) mq.push_back(in_phase);
      end
    end
  end

  // Monitor: compares every presented event and the steady outputs.
  ev_t ev;
  int  exp_gp;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        if (missed) begin
          if (sb.size() == 0 || !sb[0].is_miss) begin
            check("missed_unexpected", int'(missed), 0);
          end else begin
            ev = sb.pop_front();
            check("missed_timing", int'(global_phase), 1);
          end
        end
        if (spike_out) begin
          if (sb.size() == 0 || sb[0].is_miss) begin
            check("spike_unexpected", int'(spike_out), 0);
          end else begin
            ev     = sb.pop_front();
            exp_gp = (int'(ev.ph) + 1 == ev.len) ? 0 : int'(ev.ph) + 1;
            check("spike_phase", int'(spike_phase), int'(ev.ph));
            check("spike_latency", int'(global_phase), exp_gp);
            last_sp = ev.ph;
          end
        end
        check("spike_phase_held", int'(spike_phase), int'(last_sp));
        check("fifo_count", int'(fifo_count), mq.size());
        check("in_ready", int'(in_ready), int'(mq.size() < 4));
        check("armed", int'(armed), int'(m_armed));
      end
    end
  end

  task automatic wait_phase(input int p);
    int g = 0;
    @(negedge clk);
    while (int'(global_phase) != p && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("wait_phase_timeout", int'(global_phase), p);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) wait_phase(0);
    repeat (2) @(negedge clk);
  endtask

  // Presents a word and holds in_valid until accepted; caller drops in_valid.
  task automatic push(input logic [7:0] w);
    int g = 0;
    in_phase = w;
    in_valid = 1'b1;
    while (!in_ready && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("push_timeout", int'(in_ready), 1);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_spike_out", int'(spike_out), 0);
    check("rst_spike_phase", int'(spike_phase), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_missed", int'(missed), 0);
    check("rst_fifo_count", int'(fifo_count), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst    = 1'b0;
    chk_on = 1'b1;

    // Four targets queued ahead of the first popping cycle_start.
    wait_phase(200);
    push(8'd1); push(8'd40); push(8'd1); push(8'd40);
    in_valid = 1'b0;
    wait_cycles(5);

    // Six words with in_valid held: the last two wait for pops.
    wait_phase(10);
    for (int i = 0; i < 6; i++) push(8'($urandom_range(1, 250)));
    in_valid = 1'b0;
    wait_cycles(7);

    // Silent gamma cycles.
    wait_cycles(3);

    // Phase 0 and the final phase of a 256-clock cycle.
    wait_phase(100);
    push(8'd0); push(8'd255);
    in_valid = 1'b0;
    wait_cycles(3);

    // Short oscillator: 200 is unreachable, 10 fires in the next cycle.
    req_len = 128;
    wait_cycles(2);
    wait_phase(50);
    push(8'd200); push(8'd10);
    in_valid = 1'b0;
    wait_cycles(4);

    // Reset while a target is armed with two more queued.
    req_len = 256;
    wait_cycles(2);
    wait_phase(200);
    push(8'd40); push(8'd50); push(8'd60);
    in_valid = 1'b0;
    wait_phase(30);
    check("pre_rst_armed", int'(armed), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_fifo_count", int'(fifo_count), 0);
    check("midrst_armed", int'(armed), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_spike_out", int'(spike_out), 0);
    wait_cycles(2);
    wait_phase(5);
    push(8'd77);
    in_valid = 1'b0;
    wait_cycles(3);

    // Randomized traffic across both oscillator lengths.
    for (int blk = 0; blk < 6; blk++) begin
      req_len = (blk % 2 == 1) ? 128 : 256;
      repeat (2500) begin
        @(negedge clk);
        in_valid = ($urandom_range(0, 99) < 2);
        case ($urandom_range(0, 9))
          0:       in_phase = 8'd0;
          1:       in_phase = 8'd255;
          2:       in_phase = 8'd127;
          default: in_phase = 8'($urandom_range(0, 255));
        endcase
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    req_len  = 256;
    wait_cycles(8);
    check("drain_pending", sb.size() + mq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
